// File: rtl/ctrl_pkg.sv
// Shared definitions for the RV32 control path: the 8-bit decoder bundle,
// the trimmed per-stage payloads, opcode and ALUOp encodings, and a
// reference opcode-to-bundle decode helper.
package ctrl_pkg;

   localparam int unsigned CTRL_W = 8;
   localparam int unsigned OP_W   = 7;

   // Major opcodes handled by the decoder
   localparam logic [OP_W-1:0] OP_R    = 7'b0110011;
   localparam logic [OP_W-1:0] OP_LW   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_SW   = 7'b0100011;
   localparam logic [OP_W-1:0] OP_BEQ  = 7'b1100011;
   localparam logic [OP_W-1:0] OP_IALU = 7'b0010011;

   // ALUOp encodings: add (address calc), subtract (compare), funct-driven
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Full decoder bundle, MSB first: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
   typedef struct packed {
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic       branch;
      logic [1:0] aluop;
   } ctrl_t;

   // Fields still needed once the instruction has left EX
   typedef struct packed {
      logic memtoreg;
      logic regwrite;
      logic memread;
      logic memwrite;
      logic branch;
   } exmem_ctrl_t;

   // Fields still needed once the instruction has left MEM
   typedef struct packed {
      logic memtoreg;
      logic regwrite;
   } memwb_ctrl_t;

   localparam ctrl_t CTRL_NOP = ctrl_t'(8'b0);

   // Reference decode of a major opcode into the control bundle
   function automatic ctrl_t ctrl_decode(input logic [OP_W-1:0] opcode);
      ctrl_t c;
      c = CTRL_NOP;
      case (opcode)
         OP_R: begin
            c.regwrite = 1'b1;
            c.aluop    = ALUOP_FUNCT;
         end
         OP_IALU: begin
            c.alusrc   = 1'b1;
            c.regwrite = 1'b1;
            c.aluop    = ALUOP_FUNCT;
         end
         OP_LW: begin
            c.alusrc   = 1'b1;
            c.memtoreg = 1'b1;
            c.regwrite = 1'b1;
            c.memread  = 1'b1;
            c.aluop    = ALUOP_ADD;
         end
         OP_SW: begin
            c.alusrc   = 1'b1;
            c.memwrite = 1'b1;
            c.aluop    = ALUOP_ADD;
         end
         OP_BEQ: begin
            c.branch   = 1'b1;
            c.aluop    = ALUOP_SUB;
         end
         default: c = CTRL_NOP;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use hazard detection with taken-branch flush priority.
// Ports:
//   ex_memread, ex_rd     : load currently in EX and its destination
//   id_rs1, id_rs2        : source fields of the instruction in ID
//   mem_branch_taken      : branch in MEM resolved taken
//   hazard, flush         : raw load-use condition / squash request
//   pc_write, ifid_write  : front-end may advance (held low only on a stall)
//   ifid_flush            : IF/ID must load a NOP
module hazard_detect #(
   parameter int unsigned REG_AW = 5
) (
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              mem_branch_taken,
   output logic              hazard,
   output logic              flush,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              ifid_flush
);

   // rs fields are compared regardless of format; a false stall is harmless
   always_comb begin
      hazard = ex_memread && (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      flush  = mem_branch_taken;
   end

   // A flush squashes the dependent instruction anyway, so it overrides the stall
   always_comb begin
      pc_write   = !hazard || flush;
      ifid_write = !hazard || flush;
      ifid_flush = flush;
   end

endmodule

// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline for the 5-stage RV32 core: carries the decoded
// bundle through ID/EX, EX/MEM and MEM/WB, inserts a bubble on load-use,
// and squashes wrong-path work when a branch resolves taken in MEM.
// Optional performance counters are built when CTRL_PIPE_PERF_EN is defined.
// Ports:
//   clk, rst_n                         : clock, async active-low reset
//   id_ctrl, id_rs1, id_rs2, id_rd     : decoded instruction in ID
//   mem_branch_taken                   : taken branch in MEM
//   ex_*, mem_*, wb_*                  : per-stage control fields and rd
//   pc_write, ifid_write, ifid_flush   : front-end stall/flush controls
//   stall_cnt, flush_cnt               : event counters (CTRL_PIPE_PERF_EN only)
module ctrl_pipe
   import ctrl_pkg::*;
#(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [7:0]        id_ctrl,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              mem_branch_taken,
   output logic              ex_alusrc,
   output logic [1:0]        ex_aluop,
   output logic [REG_AW-1:0] ex_rd,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic              mem_branch,
   output logic [REG_AW-1:0] mem_rd,
   output logic              wb_memtoreg,
   output logic              wb_regwrite,
   output logic [REG_AW-1:0] wb_rd,
   output logic              pc_write,
   output logic              ifid_write,
`ifdef CTRL_PIPE_PERF_EN
   output logic              ifid_flush,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
`else
   output logic              ifid_flush
`endif
);

   ctrl_t             idex_ctrl_q,  idex_ctrl_d;
   logic [REG_AW-1:0] idex_rd_q,    idex_rd_d;
   exmem_ctrl_t       exmem_ctrl_q, exmem_ctrl_d;
   logic [REG_AW-1:0] exmem_rd_q,   exmem_rd_d;
   memwb_ctrl_t       memwb_ctrl_q, memwb_ctrl_d;
   logic [REG_AW-1:0] memwb_rd_q,   memwb_rd_d;

   logic hazard;
   logic flush;

   // Load-use and flush arbitration
   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard_detect (
      .ex_memread       (idex_ctrl_q.memread),
      .ex_rd            (idex_rd_q),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .mem_branch_taken (mem_branch_taken),
      .hazard           (hazard),
      .flush            (flush),
      .pc_write         (pc_write),
      .ifid_write       (ifid_write),
      .ifid_flush       (ifid_flush)
   );

   // Next-state: normal advance, bubble into ID/EX on stall, or squash ID/EX and EX/MEM on flush
   always_comb begin
      idex_ctrl_d           = ctrl_t'(id_ctrl);
      idex_rd_d             = id_rd;
      exmem_ctrl_d.memtoreg = idex_ctrl_q.memtoreg;
      exmem_ctrl_d.regwrite = idex_ctrl_q.regwrite;
      exmem_ctrl_d.memread  = idex_ctrl_q.memread;
      exmem_ctrl_d.memwrite = idex_ctrl_q.memwrite;
      exmem_ctrl_d.branch   = idex_ctrl_q.branch;
      exmem_rd_d            = idex_rd_q;
      // MEM/WB always advances so the resolving branch itself retires
      memwb_ctrl_d.memtoreg = exmem_ctrl_q.memtoreg;
      memwb_ctrl_d.regwrite = exmem_ctrl_q.regwrite;
      memwb_rd_d            = exmem_rd_q;

      if (flush) begin
         idex_ctrl_d  = CTRL_NOP;
         idex_rd_d    = '0;
         exmem_ctrl_d = '0;
         exmem_rd_d   = '0;
      end else if (hazard) begin
         idex_ctrl_d  = CTRL_NOP;
         idex_rd_d    = '0;
      end
   end

   // Stage registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idex_ctrl_q  <= CTRL_NOP;
         idex_rd_q    <= '0;
         exmem_ctrl_q <= '0;
         exmem_rd_q   <= '0;
         memwb_ctrl_q <= '0;
         memwb_rd_q   <= '0;
      end else begin
         idex_ctrl_q  <= idex_ctrl_d;
         idex_rd_q    <= idex_rd_d;
         exmem_ctrl_q <= exmem_ctrl_d;
         exmem_rd_q   <= exmem_rd_d;
         memwb_ctrl_q <= memwb_ctrl_d;
         memwb_rd_q   <= memwb_rd_d;
      end
   end

   // Stage outputs come straight from the pipeline registers
   always_comb begin
      ex_alusrc    = idex_ctrl_q.alusrc;
      ex_aluop     = idex_ctrl_q.aluop;
      ex_rd        = idex_rd_q;
      mem_memread  = exmem_ctrl_q.memread;
      mem_memwrite = exmem_ctrl_q.memwrite;
      mem_branch   = exmem_ctrl_q.branch;
      mem_rd       = exmem_rd_q;
      wb_memtoreg  = memwb_ctrl_q.memtoreg;
      wb_regwrite  = memwb_ctrl_q.regwrite;
      wb_rd        = memwb_rd_q;
   end

`ifdef CTRL_PIPE_PERF_EN
   // Stall and flush event counters, wrapping modulo 2^CNT_W
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (hazard && !flush) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (flush) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end
`else
   // Counter width has no consumer without the counters
   logic [31:0] cnt_w_unused;
   assign cnt_w_unused = 32'(CNT_W);
`endif

endmodule

// File: tb/tb_ctrl_pipe.sv
// Scoreboard bench for ctrl_pipe: the stimulus process drives one directed
// vector per cycle and queues hand-computed expectations; a monitor pops and
// compares them on the falling edge.
module tb_ctrl_pipe;

   localparam int unsigned REG_AW = 5;
   localparam int unsigned CNT_W  = 32;

   // Output selectors
   localparam int S_EX_ALUSRC  = 0;
   localparam int S_EX_ALUOP   = 1;
   localparam int S_EX_RD      = 2;
   localparam int S_MEM_RD_EN  = 3;
   localparam int S_MEM_WR_EN  = 4;
   localparam int S_MEM_BRANCH = 5;
   localparam int S_MEM_RD     = 6;
   localparam int S_WB_M2R     = 7;
   localparam int S_WB_REGW    = 8;
   localparam int S_WB_RD      = 9;
   localparam int S_PC_WRITE   = 10;
   localparam int S_IFID_WRITE = 11;
   localparam int S_IFID_FLUSH = 12;
   localparam int S_STALL_CNT  = 13;
   localparam int S_FLUSH_CNT  = 14;

   // Bundles: {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp}
   localparam logic [7:0] B_NOP = 8'b000000_00;
   localparam logic [7:0] B_R   = 8'b001000_10;
   localparam logic [7:0] B_LW  = 8'b111100_00;
   localparam logic [7:0] B_SW  = 8'b100010_00;
   localparam logic [7:0] B_BEQ = 8'b000001_01;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [7:0]        id_ctrl;
   logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
   logic              mem_branch_taken;
   logic              ex_alusrc;
   logic [1:0]        ex_aluop;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_memread, mem_memwrite, mem_branch;
   logic [REG_AW-1:0] mem_rd;
   logic              wb_memtoreg, wb_regwrite;
   logic [REG_AW-1:0] wb_rd;
   logic              pc_write, ifid_write, ifid_flush;
`ifdef CTRL_PIPE_PERF_EN
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   int          q_cyc[$];
   int          q_sel[$];
   logic [31:0] q_val[$];
   string       q_name[$];

   ctrl_pipe #(
      .REG_AW (REG_AW),
      .CNT_W  (CNT_W)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .id_ctrl          (id_ctrl),
      .id_rs1           (id_rs1),
      .id_rs2           (id_rs2),
      .id_rd            (id_rd),
      .mem_branch_taken (mem_branch_taken),
      .ex_alusrc        (ex_alusrc),
      .ex_aluop         (ex_aluop),
      .ex_rd            (ex_rd),
      .mem_memread      (mem_memread),
      .mem_memwrite     (mem_memwrite),
      .mem_branch       (mem_branch),
      .mem_rd           (mem_rd),
      .wb_memtoreg      (wb_memtoreg),
      .wb_regwrite      (wb_regwrite),
      .wb_rd            (wb_rd),
      .pc_write         (pc_write),
      .ifid_write       (ifid_write),
`ifdef CTRL_PIPE_PERF_EN
      .ifid_flush       (ifid_flush),
      .stall_cnt        (stall_cnt),
      .flush_cnt        (flush_cnt)
`else
      .ifid_flush       (ifid_flush)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] sample(input int sel);
      case (sel)
         S_EX_ALUSRC:  return 32'(ex_alusrc);
         S_EX_ALUOP:   return 32'(ex_aluop);
         S_EX_RD:      return 32'(ex_rd);
         S_MEM_RD_EN:  return 32'(mem_memread);
         S_MEM_WR_EN:  return 32'(mem_memwrite);
         S_MEM_BRANCH: return 32'(mem_branch);
         S_MEM_RD:     return 32'(mem_rd);
         S_WB_M2R:     return 32'(wb_memtoreg);
         S_WB_REGW:    return 32'(wb_regwrite);
         S_WB_RD:      return 32'(wb_rd);
         S_PC_WRITE:   return 32'(pc_write);
         S_IFID_WRITE: return 32'(ifid_write);
         S_IFID_FLUSH: return 32'(ifid_flush);
`ifdef CTRL_PIPE_PERF_EN
         S_STALL_CNT:  return 32'(stall_cnt);
         S_FLUSH_CNT:  return 32'(flush_cnt);
`endif
         default:      return 32'hDEAD_BEEF;
      endcase
   endfunction

   // Queue an expectation for the current cycle
   task automatic chk(input string nm, input int sel, input logic [31:0] v);
      q_cyc.push_back(cyc);
      q_sel.push_back(sel);
      q_val.push_back(v);
      q_name.push_back(nm);
   endtask

   // Apply one vector just after the rising edge
   task automatic drive(input logic [7:0] c, input logic [REG_AW-1:0] r1,
                        input logic [REG_AW-1:0] r2, input logic [REG_AW-1:0] d,
                        input logic tk);
      @(posedge clk);
      #1;
      cyc++;
      id_ctrl          = c;
      id_rs1           = r1;
      id_rs2           = r2;
      id_rd            = d;
      mem_branch_taken = tk;
   endtask

   task automatic idle();
      drive(B_NOP, 5'd0, 5'd0, 5'd0, 1'b0);
   endtask

   // Monitor: compare all expectations for this cycle on the falling edge
   always @(negedge clk) begin
      while (q_cyc.size() > 0 && q_cyc[0] == cyc) begin
         int          sel;
         logic [31:0] exp_v;
         logic [31:0] act_v;
         string       nm;
         sel   = q_sel.pop_front();
         exp_v = q_val.pop_front();
         nm    = q_name.pop_front();
         void'(q_cyc.pop_front());
         act_v = sample(sel);
         checks++;
         if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", nm, cyc, act_v, exp_v);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n            = 1'b0;
      id_ctrl          = B_NOP;
      id_rs1           = '0;
      id_rs2           = '0;
      id_rd            = '0;
      mem_branch_taken = 1'b0;

      // Reset state
      idle();
      chk("rst_ex_alusrc", S_EX_ALUSRC, 0);
      chk("rst_ex_aluop", S_EX_ALUOP, 0);
      chk("rst_mem_memread", S_MEM_RD_EN, 0);
      chk("rst_wb_regwrite", S_WB_REGW, 0);
      chk("rst_pc_write", S_PC_WRITE, 1);
      chk("rst_ifid_write", S_IFID_WRITE, 1);
      chk("rst_ifid_flush", S_IFID_FLUSH, 0);
`ifdef CTRL_PIPE_PERF_EN
      chk("rst_stall_cnt", S_STALL_CNT, 0);
      chk("rst_flush_cnt", S_FLUSH_CNT, 0);
`endif

      // Latency: R-type rd=5
      drive(B_R, 5'd1, 5'd2, 5'd5, 1'b0);
      rst_n = 1'b1;
      chk("lat_pc_write", S_PC_WRITE, 1);
      idle();
      chk("lat_ex_aluop", S_EX_ALUOP, 2);
      chk("lat_ex_rd", S_EX_RD, 5);
      chk("lat_ex_alusrc", S_EX_ALUSRC, 0);
      idle();
      chk("lat_mem_rd", S_MEM_RD, 5);
      chk("lat_ex_rd_cleared", S_EX_RD, 0);
      idle();
      chk("lat_wb_regwrite", S_WB_REGW, 1);
      chk("lat_wb_rd", S_WB_RD, 5);
      chk("lat_wb_memtoreg", S_WB_M2R, 0);
      idle();
      chk("lat_wb_regwrite_gone", S_WB_REGW, 0);

      // Load-use: lw x3, then add rd=7 rs1=x3
      drive(B_LW, 5'd1, 5'd0, 5'd3, 1'b0);
      chk("lu_pc_write_pre", S_PC_WRITE, 1);
      drive(B_R, 5'd3, 5'd2, 5'd7, 1'b0);
      chk("lu_pc_write_stall", S_PC_WRITE, 0);
      chk("lu_ifid_write_stall", S_IFID_WRITE, 0);
      chk("lu_ifid_flush", S_IFID_FLUSH, 0);
      chk("lu_ex_rd_lw", S_EX_RD, 3);
      chk("lu_ex_alusrc_lw", S_EX_ALUSRC, 1);
      drive(B_R, 5'd3, 5'd2, 5'd7, 1'b0);
      chk("lu_pc_write_released", S_PC_WRITE, 1);
      chk("lu_bubble_ex_rd", S_EX_RD, 0);
      chk("lu_bubble_ex_aluop", S_EX_ALUOP, 0);
      chk("lu_mem_memread", S_MEM_RD_EN, 1);
      chk("lu_mem_rd", S_MEM_RD, 3);
      idle();
      chk("lu_add_ex_aluop", S_EX_ALUOP, 2);
      chk("lu_add_ex_rd", S_EX_RD, 7);
      chk("lu_bubble_mem_memread", S_MEM_RD_EN, 0);
      chk("lu_lw_wb_memtoreg", S_WB_M2R, 1);
      chk("lu_lw_wb_regwrite", S_WB_REGW, 1);
      chk("lu_lw_wb_rd", S_WB_RD, 3);
      idle();
      chk("lu_add_mem_rd", S_MEM_RD, 7);
      chk("lu_bubble_wb_regwrite", S_WB_REGW, 0);
      idle();
      chk("lu_add_wb_rd", S_WB_RD, 7);
      chk("lu_add_wb_regwrite", S_WB_REGW, 1);
      chk("lu_add_wb_memtoreg", S_WB_M2R, 0);

      // x0 exemption: lw x0, then R rd=4 rs1=x0
      drive(B_LW, 5'd1, 5'd0, 5'd0, 1'b0);
      drive(B_R, 5'd0, 5'd0, 5'd4, 1'b0);
      chk("x0_pc_write", S_PC_WRITE, 1);
      chk("x0_ifid_write", S_IFID_WRITE, 1);
      chk("x0_ex_alusrc", S_EX_ALUSRC, 1);
      idle();
      chk("x0_ex_rd_on_time", S_EX_RD, 4);
      chk("x0_ex_aluop_on_time", S_EX_ALUOP, 2);
      chk("x0_mem_memread", S_MEM_RD_EN, 1);
      idle();
      chk("x0_wb_memtoreg", S_WB_M2R, 1);
      chk("x0_wb_rd", S_WB_RD, 0);
      chk("x0_mem_rd", S_MEM_RD, 4);
      idle();
      chk("x0_r_wb_rd", S_WB_RD, 4);

      // Taken branch: beq, sw rd=9, sw rd=10; taken when beq is in MEM
      drive(B_BEQ, 5'd1, 5'd2, 5'd0, 1'b0);
      drive(B_SW, 5'd1, 5'd2, 5'd9, 1'b0);
      chk("br_ex_aluop", S_EX_ALUOP, 1);
      chk("br_ex_alusrc", S_EX_ALUSRC, 0);
      chk("br_mem_branch_pre", S_MEM_BRANCH, 0);
      drive(B_SW, 5'd1, 5'd2, 5'd10, 1'b1);
      chk("br_mem_branch", S_MEM_BRANCH, 1);
      chk("br_mem_memwrite", S_MEM_WR_EN, 0);
      chk("br_ifid_flush", S_IFID_FLUSH, 1);
      chk("br_pc_write", S_PC_WRITE, 1);
      chk("br_sw1_ex_rd", S_EX_RD, 9);
      chk("br_sw1_ex_alusrc", S_EX_ALUSRC, 1);
      idle();
      chk("br_idex_zero_alusrc", S_EX_ALUSRC, 0);
      chk("br_idex_zero_rd", S_EX_RD, 0);
      chk("br_exmem_zero_memwrite", S_MEM_WR_EN, 0);
      chk("br_exmem_zero_branch", S_MEM_BRANCH, 0);
      chk("br_exmem_zero_rd", S_MEM_RD, 0);
      chk("br_beq_wb_regwrite", S_WB_REGW, 0);
      chk("br_ifid_flush_clear", S_IFID_FLUSH, 0);
      idle();
      chk("br_sw_never_mem", S_MEM_WR_EN, 0);
      chk("br_wb_regwrite", S_WB_REGW, 0);

      // Async reset while lw x11 sits in EX/MEM
      drive(B_LW, 5'd1, 5'd0, 5'd11, 1'b0);
      idle();
      chk("ar_ex_rd_pre", S_EX_RD, 11);
`ifdef CTRL_PIPE_PERF_EN
      chk("ar_stall_cnt_pre", S_STALL_CNT, 1);
      chk("ar_flush_cnt_pre", S_FLUSH_CNT, 1);
`endif
      idle();
      #2;
      rst_n = 1'b0;
      chk("ar_mem_memread", S_MEM_RD_EN, 0);
      chk("ar_mem_rd", S_MEM_RD, 0);
      chk("ar_ex_rd", S_EX_RD, 0);
      chk("ar_wb_regwrite", S_WB_REGW, 0);
      chk("ar_wb_memtoreg", S_WB_M2R, 0);
      chk("ar_wb_rd", S_WB_RD, 0);
      chk("ar_pc_write", S_PC_WRITE, 1);
      chk("ar_ifid_write", S_IFID_WRITE, 1);
      chk("ar_ifid_flush", S_IFID_FLUSH, 0);
`ifdef CTRL_PIPE_PERF_EN
      chk("ar_stall_cnt", S_STALL_CNT, 0);
      chk("ar_flush_cnt", S_FLUSH_CNT, 0);
`endif
      idle();
      rst_n = 1'b1;
      chk("ar_post_mem_memread", S_MEM_RD_EN, 0);

      // Flush beats hazard: lw x6, then add rs1=x6 with taken branch
      drive(B_LW, 5'd0, 5'd0, 5'd6, 1'b0);
      drive(B_R, 5'd6, 5'd0, 5'd8, 1'b1);
      chk("fh_pc_write", S_PC_WRITE, 1);
      chk("fh_ifid_write", S_IFID_WRITE, 1);
      chk("fh_ifid_flush", S_IFID_FLUSH, 1);
      chk("fh_ex_rd", S_EX_RD, 6);
      idle();
      chk("fh_ex_rd_squashed", S_EX_RD, 0);
      chk("fh_ex_aluop_squashed", S_EX_ALUOP, 0);
      chk("fh_mem_memread_squashed", S_MEM_RD_EN, 0);
      chk("fh_mem_rd_squashed", S_MEM_RD, 0);
      chk("fh_pc_write_after", S_PC_WRITE, 1);
`ifdef CTRL_PIPE_PERF_EN
      chk("fh_flush_cnt", S_FLUSH_CNT, 1);
      chk("fh_stall_cnt", S_STALL_CNT, 0);
`endif

      // Hazard through rs2: lw x12, then sw with rs2=x12
      drive(B_LW, 5'd0, 5'd0, 5'd12, 1'b0);
      drive(B_SW, 5'd1, 5'd12, 5'd0, 1'b0);
      chk("rs2_pc_write", S_PC_WRITE, 0);
      chk("rs2_ifid_write", S_IFID_WRITE, 0);
      drive(B_SW, 5'd1, 5'd12, 5'd0, 1'b0);
      chk("rs2_pc_write_released", S_PC_WRITE, 1);
      chk("rs2_bubble_ex_alusrc", S_EX_ALUSRC, 0);
`ifdef CTRL_PIPE_PERF_EN
      chk("rs2_stall_cnt", S_STALL_CNT, 1);
      chk("rs2_flush_cnt", S_FLUSH_CNT, 1);
`endif
      idle();
      chk("rs2_sw_ex_alusrc", S_EX_ALUSRC, 1);

      // Let the monitor drain, then flag anything it never reached
      @(negedge clk);
      #1;
      if (q_cyc.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, expected 0", q_cyc.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ctrl_pipe.md
# ctrl_pipe

Carries the decoded 8-bit control bundle from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RV32 core, and delivers each field in the stage that uses it. It also detects load-use hazards and inserts bubbles, and it squashes wrong-path instructions when a branch resolves taken in MEM. It is the consumer end of the opcode decoder's control interface.

## Interface
Parameters:
- `REG_AW`, default 5: register-index width.
- `CNT_W`, default 32: performance-counter width (used only with the Configuration macro).

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `id_ctrl`  in  8  decoder bundle `{ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, ALUOp[1:0]}`.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_AW  register fields of the instruction in ID.
- `mem_branch_taken`  in  1  branch in MEM is taken (Branch & zero).
- `ex_alusrc`  out  1
- `ex_aluop`  out  2
- `ex_rd`  out  REG_AW
- `mem_memread`, `mem_memwrite`, `mem_branch`  out  1 each
- `mem_rd`  out  REG_AW
- `wb_memtoreg`, `wb_regwrite`  out  1 each
- `wb_rd`  out  REG_AW
- `pc_write`  out  1  PC may advance.
- `ifid_write`  out  1  IF/ID may load.
- `ifid_flush`  out  1  IF/ID must load a NOP.
- `stall_cnt`, `flush_cnt`  out  CNT_W  only with `CTRL_PIPE_PERF_EN`.

## Operation
- Three registered stages: `ID/EX`, `EX/MEM` and `MEM/WB`.
  - Each stage holds the full 8-bit bundle plus rd.
  - Fields that no later stage needs may be dropped after their stage.
- Load-use hazard (combinational):
  - `hazard = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2))`.
  - The check is conservative: rs fields are compared whatever the instruction format.
- Flush: `flush = mem_branch_taken`.
- Priority is flush over hazard. When `flush` is 1, `hazard` is ignored.
- Next-state at each edge:
  - If `flush`: ID/EX ← 0 and EX/MEM ← 0. MEM/WB ← EX/MEM as normal, so the branch itself retires. The branch has RegWrite=0.
  - Else if `hazard`: ID/EX ← 0 (bubble). EX/MEM and MEM/WB advance normally.
  - Else: ID/EX ← {id_ctrl, id_rd}, and every stage advances.
- Combinational outputs:
  - `pc_write = ~hazard | flush`
  - `ifid_write = ~hazard | flush`
  - `ifid_flush = flush`
- A zero bundle is a true NOP: it causes no memory access and no register write.
- There is no back-pressure, so the pipeline never stalls more than one cycle per load-use pair.

## Timing
- Reset (`rst_n` low, asynchronous): every stage register is 0, so every `ex_*`, `mem_*` and `wb_*` output is 0. `pc_write` = 1, `ifid_write` = 1, `ifid_flush` = 0. Counters = 0.
- Reset asserted mid-operation clears all stages immediately. No pending write survives.
- Latency: a bundle presented at ID at edge N appears on `ex_*` after edge N, on `mem_*` after edge N+1, and on `wb_*` after edge N+2.
- The hazard stall lasts exactly one cycle. The bubble sits in EX on the following cycle, so `ex_memread` = 0 and the hazard deasserts.
- Back-to-back taken branch and hazard in the same cycle: flush wins and no stall occurs.

## Configuration
- Macro: `CTRL_PIPE_PERF_EN`.
- When defined:
  - `stall_cnt` increments on every edge where `hazard & ~flush`.
  - `flush_cnt` increments on every edge where `flush`.
  - Both counters are CNT_W wide, wrap modulo 2^CNT_W, and are cleared by reset.
- When undefined, the counter ports and logic are absent.

## Structure
- Shared package `ctrl_pkg` holds:
  - a packed struct for the 8-bit bundle;
  - localparams for opcodes (R 0110011, LW 0000011, SW 0100011, BEQ 1100011, I-ALU 0010011);
  - the ALUOp encodings 00, 01 and 10;
  - `CTRL_NOP` = 8'b0.
- Sub-module `hazard_detect` holds the combinational load-use and flush priority logic, and drives `hazard`, `pc_write`, `ifid_write` and `ifid_flush`.

## Test plan
- Reset-and-latency check:
  - Stimulus: reset, release, then id_ctrl=8'b001000_10 (R-type) with rd=5.
  - Required: ex_aluop=10 one edge later; `wb_regwrite`=1 with `wb_rd`=5 three edges after the input.
- Load-use stall:
  - Stimulus: lw with rd=3, followed by add with rs1=3.
  - Required: `hazard` and `pc_write`=0 for one cycle; ID/EX receives a zero bundle; the add enters EX one cycle late.
- rd=x0 exemption:
  - Stimulus: lw with rd=0, followed by an instruction with rs1=0.
  - Required: no stall; `pc_write` stays 1.
- Taken branch:
  - Stimulus: beq (8'b000001_01) followed by two sw; `mem_branch_taken`=1 when the beq reaches MEM.
  - Required: the next edge zeroes ID/EX and EX/MEM; `ifid_flush`=1; `mem_memwrite` never asserts for either sw.
- Flush beats hazard:
  - Stimulus: `mem_branch_taken`=1 in the same cycle the load-use condition holds.
  - Required: `pc_write`=1 and no stall; with `CTRL_PIPE_PERF_EN`, `flush_cnt`=1 and `stall_cnt`=0.
- Asynchronous reset mid-flight:
  - Stimulus: drop `rst_n` between clock edges while an lw is in EX/MEM.
  - Required: all outputs are 0 immediately, before the next edge.
